tone_generator: RTL and testbench

//   Converts the 5-bit note code produced by the auto-player / free-play stage into a square-wave

---
 rtl/tone_generator.sv | 153 +++++++++++++++
 tb/tb_tone_generator.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tone_generator.sv
// Note-code to square-wave speaker driver; pitch changes only on full-period boundaries.
// Optional PWM volume gating is built when the macro TONE_VOLUME_EN is defined.
module tone_generator #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] note,
`ifdef TONE_VOLUME_EN
  input  logic [2:0] vol,
`endif
  output logic       speaker,
  output logic       busy,
  output logic [4:0] cur_note,
  output logic       period_tick
);

  localparam int CNT_W = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  function automatic int unsigned low_freq(input int unsigned idx);
    case (idx)
      0:       return 131;
      1:       return 147;
      2:       return 165;
      3:       return 175;
      4:       return 196;
      5:       return 220;
      default: return 247;
    endcase
  endfunction

  // Half-periods below one cycle or beyond the counter range are pinned to the nearest legal value.
  function automatic logic [CNT_W-1:0] sat_half(input logic [63:0] h);
    if (h == 64'd0) return 20'd1;
    if (h > 64'h0000_0000_000F_FFFF) return '1;
    return h[CNT_W-1:0];
  endfunction

  function automatic logic [31:0][CNT_W-1:0] build_half_tab();
    logic [31:0][CNT_W-1:0] tab;
    logic [63:0]            f;
    int unsigned            k;
    for (int c = 0; c < 32; c++) begin
      if (c >= 1 && c <= 21) begin
        k = 32'(c) - 32'd1;
        f = 64'(low_freq(k % 7)) << (k / 7);
        tab[5'(c)] = sat_half(64'(CLK_FREQ) / (64'd2 * f));
      end else begin
        tab[5'(c)] = 20'd1;
      end
    end
    return tab;
  endfunction

  localparam logic [31:0][CNT_W-1:0] HALF_TAB = build_half_tab();

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cur_q, cur_d;
  logic [4:0]       note_q, note_d;
  logic [CNT_W-1:0] half_cur;
  logic             half_last;
  logic             tick;

  // Out-of-range codes are treated as rests at the input register.
  assign note_d    = (note > 5'd21) ? 5'd0 : note;
  assign half_cur  = HALF_TAB[cur_q];
  assign half_last = (cnt_q == half_cur - 20'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      note_q  <= note_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    tick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        cur_d = '0;
        if (note_q != 5'd0) begin
          cur_d   = note_q;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (half_last) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_LOW: begin
        if (half_last) begin
          // Period boundary: the only point where the sounding note may change or stop.
          tick  = 1'b1;
          cnt_d = '0;
          if (note_q == 5'd0) begin
            cur_d   = '0;
            state_d = S_IDLE;
          end else begin
            cur_d   = note_q;
            state_d = S_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        cur_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef TONE_VOLUME_EN
  logic [2:0] pwm_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_q + 3'd1;
  end

  assign speaker = (state_q == S_HIGH) && (pwm_cnt_q <= vol);
`else
  assign speaker = (state_q == S_HIGH);
`endif

  assign busy        = (state_q != S_IDLE);
  assign cur_note    = cur_q;
  assign period_tick = tick;

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator at CLK_FREQ=2620 (HALF(8)=5, HALF(1)=10, HALF(21)=1).
module tb_tone_generator;

  logic       clk;
  logic       rst;
  logic [4:0] note;
  logic       speaker;
  logic       busy;
  logic [4:0] cur_note;
  logic       period_tick;
`ifdef TONE_VOLUME_EN
  logic [2:0] vol;
`endif

  int total = 0;
  int bad   = 0;

  tone_generator #(.CLK_FREQ(2620)) dut (
    .clk         (clk),
    .rst         (rst),
    .note        (note),
`ifdef TONE_VOLUME_EN
    .vol         (vol),
`endif
    .speaker     (speaker),
    .busy        (busy),
    .cur_note    (cur_note),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and compare all outputs just after the edge.
  task automatic expect_cycle(input string tag, input logic spk, input logic bsy,
                              input logic [4:0] cur, input logic tck);
    @(posedge clk);
    #1;
    check({tag, ".speaker"},     32'(speaker),     32'(spk));
    check({tag, ".busy"},        32'(busy),        32'(bsy));
    check({tag, ".cur_note"},    32'(cur_note),    32'(cur));
    check({tag, ".period_tick"}, 32'(period_tick), 32'(tck));
  endtask

  initial begin
    rst  = 1'b1;
    note = 5'd8;
`ifdef TONE_VOLUME_EN
    vol  = 3'd7;
`endif

    // Reset held with a live note: outputs stay quiet.
    repeat (20) expect_cycle("reset_hold", 1'b0, 1'b0, 5'd0, 1'b0);
    rst  = 1'b0;
    note = 5'd0;
    repeat (3) expect_cycle("idle", 1'b0, 1'b0, 5'd0, 1'b0);

    // note=8 from IDLE: high on cycles 2..6, low 7..11, tick on 11, period 10.
    note = 5'd8;
    expect_cycle("n8_lat", 1'b0, 1'b0, 5'd0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      repeat (5) expect_cycle("n8_high", 1'b1, 1'b1, 5'd8, 1'b0);
      repeat (4) expect_cycle("n8_low", 1'b0, 1'b1, 5'd8, 1'b0);
      expect_cycle("n8_tick", 1'b0, 1'b1, 5'd8, 1'b1);
    end

    // 8 -> 1 in the second high cycle: old period finishes, then 10/10.
    repeat (2) expect_cycle("chg_high_a", 1'b1, 1'b1, 5'd8, 1'b0);
    note = 5'd1;
    repeat (3) expect_cycle("chg_high_b", 1'b1, 1'b1, 5'd8, 1'b0);
    repeat (4) expect_cycle("chg_low", 1'b0, 1'b1, 5'd8, 1'b0);
    expect_cycle("chg_tick", 1'b0, 1'b1, 5'd8, 1'b1);
    repeat (10) expect_cycle("n1_high", 1'b1, 1'b1, 5'd1, 1'b0);
    repeat (9) expect_cycle("n1_low", 1'b0, 1'b1, 5'd1, 1'b0);
    expect_cycle("n1_tick", 1'b0, 1'b1, 5'd1, 1'b1);

    // Rest mid-high: period completes, then IDLE.
    repeat (3) expect_cycle("rest_high_a", 1'b1, 1'b1, 5'd1, 1'b0);
    note = 5'd0;
    repeat (7) expect_cycle("rest_high_b", 1'b1, 1'b1, 5'd1, 1'b0);
    repeat (9) expect_cycle("rest_low", 1'b0, 1'b1, 5'd1, 1'b0);
    expect_cycle("rest_tick", 1'b0, 1'b1, 5'd1, 1'b1);
    repeat (5) expect_cycle("rest_idle", 1'b0, 1'b0, 5'd0, 1'b0);

    // Code 22 is a rest.
    note = 5'd22;
    repeat (6) expect_cycle("code22", 1'b0, 1'b0, 5'd0, 1'b0);
    note = 5'd31;
    repeat (3) expect_cycle("code31", 1'b0, 1'b0, 5'd0, 1'b0);

    // HALF(21)=1: one high, one low with tick, each period.
    note = 5'd21;
    expect_cycle("n21_lat", 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (3) begin
      expect_cycle("n21_high", 1'b1, 1'b1, 5'd21, 1'b0);
      expect_cycle("n21_low", 1'b0, 1'b1, 5'd21, 1'b1);
    end
    note = 5'd0;
    expect_cycle("n21_last_high", 1'b1, 1'b1, 5'd21, 1'b0);
    expect_cycle("n21_last_low", 1'b0, 1'b1, 5'd21, 1'b1);
    repeat (2) expect_cycle("n21_idle", 1'b0, 1'b0, 5'd0, 1'b0);

    // One-cycle pulse that reached note_q: exactly one full period.
    note = 5'd8;
    expect_cycle("pulse_lat", 1'b0, 1'b0, 5'd0, 1'b0);
    note = 5'd0;
    repeat (5) expect_cycle("pulse_high", 1'b1, 1'b1, 5'd8, 1'b0);
    repeat (4) expect_cycle("pulse_low", 1'b0, 1'b1, 5'd8, 1'b0);
    expect_cycle("pulse_tick", 1'b0, 1'b1, 5'd8, 1'b1);
    repeat (3) expect_cycle("pulse_idle", 1'b0, 1'b0, 5'd0, 1'b0);

    // Reset mid-period aborts immediately.
    note = 5'd8;
    expect_cycle("abort_lat", 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (2) expect_cycle("abort_high", 1'b1, 1'b1, 5'd8, 1'b0);
    rst = 1'b1;
    repeat (2) expect_cycle("abort_rst", 1'b0, 1'b0, 5'd0, 1'b0);
    rst  = 1'b0;
    note = 5'd0;
    repeat (2) expect_cycle("abort_idle", 1'b0, 1'b0, 5'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
